// File: rtl/hex_probe_pager_if.sv
// rtl/hex_probe_pager_if.sv - probe bus, paging controls and display outputs of hex_probe_pager
interface hex_probe_pager_if #(
  parameter int NUM_CH     = 4,
  parameter int CH_WIDTH   = 16,
  parameter int NUM_DIGITS = 8
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*CH_WIDTH-1:0] ch_data;
  logic                       step;
  logic                       freeze;
  logic                       auto_en;
  logic                       sel_load;
  logic [PW-1:0]              sel_page;
  logic [NUM_DIGITS*7-1:0]    seg;
  logic [PW-1:0]              page;
  logic                       frozen;
  logic                       tick;

  modport master (
    output ch_data, step, freeze, auto_en, sel_load, sel_page,
    input  seg, page, frozen, tick
  );

  modport slave (
    input  ch_data, step, freeze, auto_en, sel_load, sel_page,
    output seg, page, frozen, tick
  );
endinterface

// File: rtl/hex_probe_pager.sv
// rtl/hex_probe_pager.sv - pages NUM_CH probe channels onto an active-low seven-segment bank
module hex_probe_pager #(
  parameter int NUM_CH      = 4,
  parameter int CH_WIDTH    = 16,
  parameter int NUM_DIGITS  = 8,
  parameter int AUTO_PERIOD = 50000000,
  parameter int SUPPRESS_LZ = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  hex_probe_pager_if.slave  io_pg
);
  localparam int PW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NIB  = (CH_WIDTH + 3) / 4;
  localparam int NIBW = NIB * 4;
  localparam int TW   = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TLAST = TW'(AUTO_PERIOD - 1);
  localparam logic [PW-1:0] PLAST = PW'(NUM_CH - 1);

  logic                       r_step_prev;
  logic                       r_freeze_prev;
  logic                       r_frozen;
  logic                       r_tick;
  logic [TW-1:0]              r_timer;
  logic [PW-1:0]              r_page;
  logic [NUM_CH*CH_WIDTH-1:0] r_snap;
  logic [NUM_CH*CH_WIDTH-1:0] r_ch;
  logic [NUM_DIGITS*7-1:0]    r_seg;

  logic                       w_step_rise;
  logic                       w_freeze_rise;
  logic                       w_auto_adv;
  logic [PW-1:0]              w_page_inc;
  logic [PW-1:0]              w_sel_page;
  logic [CH_WIDTH-1:0]        w_src;
  logic [NIBW-1:0]            w_src_pad;
  logic                       w_upper_zero;
  logic [NUM_DIGITS*7-1:0]    w_seg;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'ha: hex7 = 7'h08;
      4'hb: hex7 = 7'h03;
      4'hc: hex7 = 7'h46;
      4'hd: hex7 = 7'h21;
      4'he: hex7 = 7'h06;
      default: hex7 = 7'h0e;
    endcase
  endfunction

  assign w_step_rise   = io_pg.step & ~r_step_prev;
  assign w_freeze_rise = io_pg.freeze & ~r_freeze_prev;
  assign w_auto_adv    = io_pg.auto_en && (r_timer == TLAST);
  assign w_page_inc    = (r_page == PLAST) ? '0 : r_page + PW'(1);
  assign w_sel_page    = (32'(io_pg.sel_page) >= NUM_CH) ? PLAST : io_pg.sel_page;

  // Source selection uses the registered page, so seg trails a page change by one cycle.
  always_comb begin
    w_src = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_page == PW'(k)) begin
        w_src = r_frozen ? r_snap[k*CH_WIDTH +: CH_WIDTH] : r_ch[k*CH_WIDTH +: CH_WIDTH];
      end
    end
  end

  assign w_src_pad = NIBW'(w_src);

  // Walk from the top nibble down so w_upper_zero covers every nibble at or above d.
  always_comb begin
    w_seg        = '1;
    w_upper_zero = 1'b1;
    for (int d = NIB - 1; d >= 0; d--) begin
      w_upper_zero = w_upper_zero & (w_src_pad[d*4 +: 4] == 4'h0);
      if (d < NUM_DIGITS) begin
        if ((SUPPRESS_LZ != 0) && (d > 0) && w_upper_zero) begin
          w_seg[d*7 +: 7] = 7'h7f;
        end else begin
          w_seg[d*7 +: 7] = hex7(w_src_pad[d*4 +: 4]);
        end
      end
    end
  end

  // Probe pipeline stage; free-running so live data is valid as soon as reset drops.
  always_ff @(posedge i_clk) begin
    r_ch <= io_pg.ch_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step_prev   <= 1'b0;
      r_freeze_prev <= 1'b0;
      r_frozen      <= 1'b0;
      r_tick        <= 1'b0;
      r_timer       <= '0;
      r_page        <= '0;
      r_snap        <= '0;
      r_seg         <= '1;
    end else begin
      r_step_prev   <= io_pg.step;
      r_freeze_prev <= io_pg.freeze;
      r_tick        <= w_auto_adv;
      r_seg         <= w_seg;

      if (!io_pg.auto_en || io_pg.sel_load || w_step_rise || w_auto_adv) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end

      if (io_pg.sel_load) begin
        r_page <= w_sel_page;
      end else if (w_step_rise || w_auto_adv) begin
        r_page <= w_page_inc;
      end

      if (w_freeze_rise) begin
        if (!r_frozen) begin
          r_snap   <= io_pg.ch_data;
          r_frozen <= 1'b1;
        end else begin
          r_frozen <= 1'b0;
        end
      end
    end
  end

  assign io_pg.seg    = r_seg;
  assign io_pg.page   = r_page;
  assign io_pg.frozen = r_frozen;
  assign io_pg.tick   = r_tick;
endmodule

// File: tb/tb_hex_probe_pager.sv
// tb/tb_hex_probe_pager.sv - directed bench for hex_probe_pager
module tb_hex_probe_pager;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hex_probe_pager_if #(.NUM_CH(4), .CH_WIDTH(16), .NUM_DIGITS(8)) if0 ();
  hex_probe_pager_if #(.NUM_CH(3), .CH_WIDTH(16), .NUM_DIGITS(8)) if1 ();
  hex_probe_pager_if #(.NUM_CH(4), .CH_WIDTH(16), .NUM_DIGITS(8)) if2 ();

  hex_probe_pager #(.NUM_CH(4), .CH_WIDTH(16), .NUM_DIGITS(8), .AUTO_PERIOD(4), .SUPPRESS_LZ(0))
    u_dut0 (.i_clk(clk), .i_reset(rst), .io_pg(if0.slave));
  hex_probe_pager #(.NUM_CH(3), .CH_WIDTH(16), .NUM_DIGITS(8), .AUTO_PERIOD(4), .SUPPRESS_LZ(0))
    u_dut1 (.i_clk(clk), .i_reset(rst), .io_pg(if1.slave));
  hex_probe_pager #(.NUM_CH(4), .CH_WIDTH(16), .NUM_DIGITS(8), .AUTO_PERIOD(4), .SUPPRESS_LZ(1))
    u_dut2 (.i_clk(clk), .i_reset(rst), .io_pg(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    if0.ch_data = {16'h0000, 16'h0000, 16'h0000, 16'h1234};
    if0.step = 0; if0.freeze = 0; if0.auto_en = 0; if0.sel_load = 0; if0.sel_page = '0;
    if1.ch_data = '0;
    if1.step = 0; if1.freeze = 0; if1.auto_en = 0; if1.sel_load = 0; if1.sel_page = '0;
    if2.ch_data = '0;
    if2.step = 0; if2.freeze = 0; if2.auto_en = 0; if2.sel_load = 0; if2.sel_page = '0;

    cyc(3);
    rst = 1'b0;
    chk("rst_seg_blank", 64'(if0.seg), 64'({8{7'h7f}}));
    chk("rst_page", 64'(if0.page), 64'd0);
    chk("rst_frozen", 64'(if0.frozen), 64'd0);
    chk("rst_tick", 64'(if0.tick), 64'd0);
    cyc(1);
    chk("first_display", 64'(if0.seg),
        64'({7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h79, 7'h24, 7'h30, 7'h19}));
    chk("first_page", 64'(if0.page), 64'd0);

    if0.step = 1;
    cyc(10);
    chk("step_held", 64'(if0.page), 64'd1);
    if0.step = 0;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] pexp [4];
      pexp = '{2'd2, 2'd3, 2'd0, 2'd1};
      if0.step = 1;
      cyc(1);
      if0.step = 0;
      cyc(1);
      chk($sformatf("step_pulse%0d", i), 64'(if0.page), 64'(pexp[i]));
    end

    if0.auto_en = 1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk($sformatf("auto_tick%0d", i), 64'(if0.tick), 64'((i % 4) == 0));
    end
    chk("auto_page", 64'(if0.page), 64'd3);
    cyc(3);
    if0.step = 1;
    cyc(1);
    chk("step_and_tick_page", 64'(if0.page), 64'd0);
    chk("step_and_tick_tick", 64'(if0.tick), 64'd1);
    if0.step = 0;
    if0.auto_en = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk($sformatf("auto_off_tick%0d", i), 64'(if0.tick), 64'd0);
    end
    chk("auto_off_page", 64'(if0.page), 64'd0);

    if0.ch_data[2*16 +: 16] = 16'hBEEF;
    if0.sel_page = 2'd2;
    if0.sel_load = 1;
    cyc(1);
    if0.sel_load = 0;
    chk("sel_page2", 64'(if0.page), 64'd2);
    cyc(2);
    chk("live_beef", 64'(if0.seg),
        64'({7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h03, 7'h06, 7'h06, 7'h0e}));
    if0.freeze = 1;
    cyc(1);
    if0.freeze = 0;
    if0.ch_data[2*16 +: 16] = 16'h0000;
    cyc(3);
    chk("frozen_set", 64'(if0.frozen), 64'd1);
    chk("frozen_beef", 64'(if0.seg),
        64'({7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h03, 7'h06, 7'h06, 7'h0e}));
    if0.freeze = 1;
    cyc(1);
    if0.freeze = 0;
    cyc(3);
    chk("frozen_clr", 64'(if0.frozen), 64'd0);
    chk("unfrozen_zero", 64'(if0.seg),
        64'({7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h40, 7'h40, 7'h40, 7'h40}));

    if0.auto_en = 1;
    cyc(2);
    if0.sel_page = 2'd3;
    if0.sel_load = 1;
    cyc(1);
    if0.sel_load = 0;
    chk("sel_page3", 64'(if0.page), 64'd3);
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      chk($sformatf("sel_timer_tick%0d", i), 64'(if0.tick), 64'(i == 4));
    end
    chk("sel_then_auto_wrap", 64'(if0.page), 64'd0);
    if0.auto_en = 0;

    if1.sel_page = 2'd3;
    if1.sel_load = 1;
    cyc(1);
    if1.sel_load = 0;
    chk("clamp_nch3", 64'(if1.page), 64'd2);
    if1.step = 1;
    cyc(1);
    if1.step = 0;
    cyc(1);
    chk("wrap_nch3", 64'(if1.page), 64'd0);

    if2.ch_data[15:0] = 16'h0005;
    cyc(3);
    chk("lz_0005", 64'(if2.seg), 64'({{7{7'h7f}}, 7'h12}));
    if2.ch_data[15:0] = 16'h0000;
    cyc(3);
    chk("lz_0000", 64'(if2.seg), 64'({{7{7'h7f}}, 7'h40}));
    if2.ch_data[15:0] = 16'h0120;
    cyc(3);
    chk("lz_0120", 64'(if2.seg), 64'({{5{7'h7f}}, 7'h79, 7'h24, 7'h40}));

    if0.sel_page = 2'd1;
    if0.sel_load = 1;
    if0.freeze = 1;
    if0.auto_en = 1;
    cyc(1);
    if0.sel_load = 0;
    if0.freeze = 0;
    chk("pre_rst_frozen", 64'(if0.frozen), 64'd1);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_frozen", 64'(if0.frozen), 64'd0);
    chk("mid_rst_page", 64'(if0.page), 64'd0);
    chk("mid_rst_seg", 64'(if0.seg), 64'({8{7'h7f}}));
    rst = 1'b0;
    if0.auto_en = 0;
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
